// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS subset: opcodes, funct codes,
// ALU control codes, ALUOp encodings and the main-control bundle.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpJ     = 6'h02;

  // R-type funct codes
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;
  localparam logic [5:0] FnNor = 6'h27;

  // ALU control codes
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  // ALUOp encodings from main control
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/mips_single_cycle_cpu_if.sv
// External memory-load bus: program loading into imem and data preload into dmem.
interface mips_single_cycle_cpu_if;

  logic        instr_write_enable;
  logic [7:0]  instr_write_addr;
  logic [31:0] instr_write_data;
  logic        data_init_write_enable;
  logic [7:0]  data_init_addr;
  logic [31:0] data_init_data;

  modport master (
    output instr_write_enable, instr_write_addr, instr_write_data,
    output data_init_write_enable, data_init_addr, data_init_data
  );

  modport slave (
    input instr_write_enable, instr_write_addr, instr_write_data,
    input data_init_write_enable, data_init_addr, data_init_data
  );

endinterface

// File: rtl/mips_datapath.sv
// Single-cycle datapath: PC, instruction/data memories, register file, ALU, next-PC.
import mips_pkg::*;

module mips_datapath #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic                clk,
  input  logic                reset,
  mips_single_cycle_cpu_if.slave load_bus,
  input  ctrl_t               ctrl,
  output logic [5:0]          opcode,
  output logic [31:0][31:0]   regs
);

  localparam int unsigned ImemAw = $clog2(IMEM_DEPTH);
  localparam int unsigned DmemAw = $clog2(DMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  logic [31:0]       pc_q, pc_d, pc_plus4;
  logic [31:0][31:0] regs_q;

  // Probe-friendly names for the main datapath nets
  logic [31:0] PC, Instruction, ALUResult, ReadData, WriteData;
  logic [3:0]  ALUControl;
  logic        Zero, RegWrite;
  logic [4:0]  WriteReg;

  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] imm_ext, rs_val, rt_val, alu_b;
  logic        funct_ok, branch_taken, store_en;
  logic        unused_shamt;

  assign PC          = pc_q;
  assign Instruction = imem[pc_q[ImemAw+1:2]];
  assign opcode      = Instruction[31:26];
  assign rs          = Instruction[25:21];
  assign rt          = Instruction[20:16];
  assign rd          = Instruction[15:11];
  assign funct       = Instruction[5:0];
  assign imm_ext     = {{16{Instruction[15]}}, Instruction[15:0]};
  assign unused_shamt = ^Instruction[10:6];

  assign rs_val = regs_q[rs];
  assign rt_val = regs_q[rt];
  assign alu_b  = ctrl.alu_src ? imm_ext : rt_val;

  // ALU control: unknown R-type funct falls back to ADD and blocks the write.
  always_comb begin
    ALUControl = AluAdd;
    funct_ok   = 1'b1;
    case (ctrl.alu_op)
      AluOpAdd: ALUControl = AluAdd;
      AluOpSub: ALUControl = AluSub;
      AluOpFunct: begin
        case (funct)
          FnAdd:   ALUControl = AluAdd;
          FnSub:   ALUControl = AluSub;
          FnAnd:   ALUControl = AluAnd;
          FnOr:    ALUControl = AluOr;
          FnSlt:   ALUControl = AluSlt;
          FnNor:   ALUControl = AluNor;
          default: funct_ok   = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign RegWrite = ctrl.reg_write & funct_ok;

  // ALU
  always_comb begin
    ALUResult = rs_val + alu_b;
    case (ALUControl)
      AluAnd:  ALUResult = rs_val & alu_b;
      AluOr:   ALUResult = rs_val | alu_b;
      AluAdd:  ALUResult = rs_val + alu_b;
      AluSub:  ALUResult = rs_val - alu_b;
      AluSlt:  ALUResult = ($signed(rs_val) < $signed(alu_b)) ? 32'd1 : 32'd0;
      AluNor:  ALUResult = ~(rs_val | alu_b);
      default: ;
    endcase
  end

  assign Zero     = (ALUResult == 32'd0);
  assign ReadData = dmem[ALUResult[DmemAw+1:2]];
  assign WriteReg = ctrl.reg_dst ? rd : rt;
  // Only loads assert both, so this matches MemtoReg for every defined opcode.
  assign WriteData = (ctrl.mem_to_reg & ctrl.mem_read) ? ReadData : ALUResult;

  // Next PC: jump beats taken branch beats PC+4.
  always_comb begin
    pc_plus4     = pc_q + 32'd4;
    branch_taken = ctrl.branch & ((opcode == OpBne) ? ~Zero : Zero);
    if (ctrl.jump) begin
      pc_d = {pc_plus4[31:28], Instruction[25:0], 2'b00};
    end else if (branch_taken) begin
      pc_d = pc_plus4 + (imm_ext << 2);
    end else begin
      pc_d = pc_plus4;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= 32'd0;
    else        pc_q <= pc_d;
  end

  // Register file; $0 is never written so it stays 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
    end else if (RegWrite && (WriteReg != 5'd0)) begin
      regs_q[WriteReg] <= WriteData;
    end
  end

  assign regs = regs_q;

  // Instruction memory load port; fetch in the same cycle still sees the old word.
  always_ff @(posedge clk) begin
    if (load_bus.instr_write_enable) begin
      imem[load_bus.instr_write_addr] <= load_bus.instr_write_data;
    end
  end

  assign store_en = ctrl.mem_write & reset;

  // Data memory: CPU store, then data_init so the external write wins on a collision.
  always_ff @(posedge clk) begin
    if (store_en) begin
      dmem[ALUResult[DmemAw+1:2]] <= rt_val;
    end
    if (load_bus.data_init_write_enable) begin
      dmem[load_bus.data_init_addr] <= load_bus.data_init_data;
    end
  end

endmodule

// File: rtl/mips_main_control.sv
// Main control decoder: opcode to datapath control bundle.
import mips_pkg::*;

module mips_main_control (
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  // Decode opcode; undefined opcodes leave everything 0 and behave as a NOP.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OpRtype: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = AluOpFunct;
      end
      OpLw: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = AluOpAdd;
      end
      OpSw: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = AluOpAdd;
      end
      OpBeq, OpBne: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = AluOpSub;
      end
      OpAddi: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = AluOpAdd;
      end
      OpJ: begin
        ctrl.jump = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_single_cycle_cpu.sv
// Single-cycle MIPS subset CPU top: control decoder plus datapath, registers exported flat.
import mips_pkg::*;

module mips_single_cycle_cpu #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_write_enable,
  input  logic [7:0]  instr_write_addr,
  input  logic [31:0] instr_write_data,
  input  logic        data_init_write_enable,
  input  logic [7:0]  data_init_addr,
  input  logic [31:0] data_init_data,
  output logic [31:0] RegValue0,  RegValue1,  RegValue2,  RegValue3,
  output logic [31:0] RegValue4,  RegValue5,  RegValue6,  RegValue7,
  output logic [31:0] RegValue8,  RegValue9,  RegValue10, RegValue11,
  output logic [31:0] RegValue12, RegValue13, RegValue14, RegValue15,
  output logic [31:0] RegValue16, RegValue17, RegValue18, RegValue19,
  output logic [31:0] RegValue20, RegValue21, RegValue22, RegValue23,
  output logic [31:0] RegValue24, RegValue25, RegValue26, RegValue27,
  output logic [31:0] RegValue28, RegValue29, RegValue30, RegValue31
);

  mips_single_cycle_cpu_if load_bus ();

  assign load_bus.instr_write_enable     = instr_write_enable;
  assign load_bus.instr_write_addr       = instr_write_addr;
  assign load_bus.instr_write_data       = instr_write_data;
  assign load_bus.data_init_write_enable = data_init_write_enable;
  assign load_bus.data_init_addr         = data_init_addr;
  assign load_bus.data_init_data         = data_init_data;

  logic [5:0]        opcode;
  ctrl_t             ctrl;
  logic [31:0][31:0] regs;

  mips_main_control control (
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  mips_datapath #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .DMEM_DEPTH (DMEM_DEPTH)
  ) datapath (
    .clk      (clk),
    .reset    (reset),
    .load_bus (load_bus.slave),
    .ctrl     (ctrl),
    .opcode   (opcode),
    .regs     (regs)
  );

  assign RegValue0  = regs[0];
  assign RegValue1  = regs[1];
  assign RegValue2  = regs[2];
  assign RegValue3  = regs[3];
  assign RegValue4  = regs[4];
  assign RegValue5  = regs[5];
  assign RegValue6  = regs[6];
  assign RegValue7  = regs[7];
  assign RegValue8  = regs[8];
  assign RegValue9  = regs[9];
  assign RegValue10 = regs[10];
  assign RegValue11 = regs[11];
  assign RegValue12 = regs[12];
  assign RegValue13 = regs[13];
  assign RegValue14 = regs[14];
  assign RegValue15 = regs[15];
  assign RegValue16 = regs[16];
  assign RegValue17 = regs[17];
  assign RegValue18 = regs[18];
  assign RegValue19 = regs[19];
  assign RegValue20 = regs[20];
  assign RegValue21 = regs[21];
  assign RegValue22 = regs[22];
  assign RegValue23 = regs[23];
  assign RegValue24 = regs[24];
  assign RegValue25 = regs[25];
  assign RegValue26 = regs[26];
  assign RegValue27 = regs[27];
  assign RegValue28 = regs[28];
  assign RegValue29 = regs[29];
  assign RegValue30 = regs[30];
  assign RegValue31 = regs[31];

endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// Directed self-checking bench for mips_single_cycle_cpu.
module tb_mips_single_cycle_cpu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_single_cycle_cpu_if tb_bus ();

  logic [31:0] rv [32];

  int checks   = 0;
  int failures = 0;

  mips_single_cycle_cpu dut (
    .clk                    (clk),
    .reset                  (reset),
    .instr_write_enable     (tb_bus.instr_write_enable),
    .instr_write_addr       (tb_bus.instr_write_addr),
    .instr_write_data       (tb_bus.instr_write_data),
    .data_init_write_enable (tb_bus.data_init_write_enable),
    .data_init_addr         (tb_bus.data_init_addr),
    .data_init_data         (tb_bus.data_init_data),
    .RegValue0 (rv[0]),   .RegValue1 (rv[1]),   .RegValue2 (rv[2]),   .RegValue3 (rv[3]),
    .RegValue4 (rv[4]),   .RegValue5 (rv[5]),   .RegValue6 (rv[6]),   .RegValue7 (rv[7]),
    .RegValue8 (rv[8]),   .RegValue9 (rv[9]),   .RegValue10(rv[10]),  .RegValue11(rv[11]),
    .RegValue12(rv[12]),  .RegValue13(rv[13]),  .RegValue14(rv[14]),  .RegValue15(rv[15]),
    .RegValue16(rv[16]),  .RegValue17(rv[17]),  .RegValue18(rv[18]),  .RegValue19(rv[19]),
    .RegValue20(rv[20]),  .RegValue21(rv[21]),  .RegValue22(rv[22]),  .RegValue23(rv[23]),
    .RegValue24(rv[24]),  .RegValue25(rv[25]),  .RegValue26(rv[26]),  .RegValue27(rv[27]),
    .RegValue28(rv[28]),  .RegValue29(rv[29]),  .RegValue30(rv[30]),  .RegValue31(rv[31])
  );

  // Program 1: ALU ops, store/load, jump, branches, $0, bad funct, bad opcode.
  logic [31:0] prog1 [23] = '{
    32'h20010005, 32'h20020007, 32'h00221820, 32'hAC030190, 32'h8C040190,
    32'h08000008, 32'h20050001, 32'h20050001, 32'h10210002, 32'h20050001,
    32'h20050001, 32'h14210002, 32'h20000009, 32'h00413022, 32'h00223824,
    32'h00224025, 32'h00224827, 32'h0121502A, 32'h0029582A, 32'h0022603F,
    32'hFC0D0001, 32'h200DFFFF, 32'h08000016
  };

  // Program 2: iterative Fibonacci, n read from dmem[0], result stored at byte 400.
  logic [31:0] prog2 [14] = '{
    32'h8C010000, 32'h20020000, 32'h20030001, 32'h20050000, 32'h00A1302A,
    32'h10C00005, 32'h00432020, 32'h00601020, 32'h00801820, 32'h20A50001,
    32'h08000004, 32'h00402020, 32'hAC040190, 32'h0800000D
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_imem(input logic [7:0] addr, input logic [31:0] data);
    tb_bus.instr_write_enable = 1'b1;
    tb_bus.instr_write_addr   = addr;
    tb_bus.instr_write_data   = data;
    tick();
    tb_bus.instr_write_enable = 1'b0;
  endtask

  task automatic load_dmem(input logic [7:0] addr, input logic [31:0] data);
    tb_bus.data_init_write_enable = 1'b1;
    tb_bus.data_init_addr         = addr;
    tb_bus.data_init_data         = data;
    tick();
    tb_bus.data_init_write_enable = 1'b0;
  endtask

  initial begin
    int cyc;
    reset                         = 1'b0;
    tb_bus.instr_write_enable     = 1'b0;
    tb_bus.instr_write_addr       = '0;
    tb_bus.instr_write_data       = '0;
    tb_bus.data_init_write_enable = 1'b0;
    tb_bus.data_init_addr         = '0;
    tb_bus.data_init_data         = '0;
    #2;

    check("reset_pc", dut.datapath.PC, 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("reset_r%0d", i), rv[i], 32'd0);

    // Load under reset: clear imem, then program 1
    for (int i = 0; i < 256; i++) load_imem(8'(i), 32'd0);
    for (int i = 0; i < 23; i++) load_imem(8'(i), prog1[i]);
    check("held_in_reset_pc", dut.datapath.PC, 32'd0);
    check("held_in_reset_r1", rv[1], 32'd0);

    reset = 1'b1;
    check("release_pc", dut.datapath.PC, 32'd0);
    repeat (3) tick();
    check("addi_r1", rv[1], 32'd5);
    check("addi_r2", rv[2], 32'd7);
    check("add_r3", rv[3], 32'd12);
    check("pc_after3", dut.datapath.PC, 32'd12);

    repeat (2) tick();
    check("sw_dmem100", dut.datapath.dmem[100], 32'd12);
    check("lw_r4", rv[4], 32'd12);
    check("pc_after5", dut.datapath.PC, 32'd20);

    tick();
    check("j_pc", dut.datapath.PC, 32'd32);
    tick();
    check("beq_taken_pc", dut.datapath.PC, 32'd44);
    tick();
    check("bne_not_taken_pc", dut.datapath.PC, 32'd48);
    check("skipped_r5", rv[5], 32'd0);
    tick();
    check("r0_stays_zero", rv[0], 32'd0);
    check("pc_after_addi0", dut.datapath.PC, 32'd52);

    repeat (6) tick();
    check("sub_r6", rv[6], 32'd2);
    check("and_r7", rv[7], 32'd5);
    check("or_r8", rv[8], 32'd7);
    check("nor_r9", rv[9], 32'hFFFF_FFF8);
    check("slt_neg_r10", rv[10], 32'd1);
    check("slt_pos_r11", rv[11], 32'd0);

    tick();
    check("bad_funct_r12", rv[12], 32'd0);
    check("pc_after_bad_funct", dut.datapath.PC, 32'd80);
    tick();
    check("bad_op_pc", dut.datapath.PC, 32'd84);
    check("bad_op_r13", rv[13], 32'd0);
    tick();
    check("addi_neg_r13", rv[13], 32'hFFFF_FFFF);
    repeat (2) tick();
    check("halt_pc", dut.datapath.PC, 32'd88);
    check("skipped_r5_end", rv[5], 32'd0);

    // Asynchronous reset in mid-cycle
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_pc", dut.datapath.PC, 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("async_reset_r%0d", i), rv[i], 32'd0);
    check("dmem_retained", dut.datapath.dmem[100], 32'd12);
    check("imem_retained", dut.datapath.Instruction, 32'h20010005);

    // Fibonacci with n preloaded into dmem[0]
    for (int i = 0; i < 14; i++) load_imem(8'(i), prog2[i]);
    load_dmem(8'd0, 32'd10);
    check("data_init_dmem0", dut.datapath.dmem[0], 32'd10);
    reset = 1'b1;
    cyc = 0;
    while (dut.datapath.PC !== 32'd52 && cyc < 400) begin
      tick();
      cyc++;
    end
    check("fib_reached_halt", dut.datapath.PC, 32'd52);
    check("fib_r4", rv[4], 32'd55);
    check("fib_r2", rv[2], 32'd55);
    check("fib_r3", rv[3], 32'd89);
    check("fib_i_r5", rv[5], 32'd10);
    check("fib_dmem100", dut.datapath.dmem[100], 32'd55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_single_cycle_cpu.md
Name: mips_single_cycle_cpu

Overview:
- Single-cycle 32-bit MIPS subset processor (one instruction retires per clock) with internal instruction memory, data memory and a 32x32 register file.
- Both memories can be written from outside: instruction memory is for program loading; data memory is for initial data.
- All 32 architectural registers are exported as flat outputs so benches and top-level debug logic can observe them.

Parameters:
- IMEM_DEPTH, 256, instruction memory words (address width 8).
- DMEM_DEPTH, 256, data memory words (address width 8).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- instr_write_enable  input  1  write instr_write_data into instruction memory at the next rising edge.
- instr_write_addr  input  8  instruction memory word address.
- instr_write_data  input  32  instruction word to store.
- data_init_write_enable  input  1  write data_init_data into data memory at the next rising edge.
- data_init_addr  input  8  data memory word address.
- data_init_data  input  32  data word to store.
- RegValue0..RegValue31  output  32 each  live contents of registers $0..$31; RegValue0 is always 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=0 and all 32 registers=0, so every RegValueN output is 0.
  - Memories are NOT cleared.
  - Both external memory write ports remain functional during reset; CPU stores and register writes are suppressed.
- Fetch:
  - Instruction = imem[PC[9:2]], combinational read; PC[1:0] is ignored.
  - Index wraps modulo 256.
  - Unwritten instruction words read as 0 (sll $0 = NOP).
- Supported instructions:
  - R-type (op 000000): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, nor 0x27.
  - I-type and J-type: lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, j 0x02.
  - Arithmetic is two's complement modulo 2^32; there are no overflow traps.
- Main control (combinational from opcode), outputs RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite:
  - R-type: RegDst=1, RegWrite=1, ALUOp=10.
  - lw: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=00.
  - sw: ALUSrc=1, MemWrite=1, ALUOp=00.
  - beq/bne: Branch=1, ALUOp=01.
  - addi: ALUSrc=1, RegWrite=1, ALUOp=00.
  - j: Jump=1.
  - Undefined opcode: all control signals 0, so the instruction acts as a NOP with PC+4.
- ALU control (4-bit):
  - ALUOp 00 selects ADD; ALUOp 01 selects SUB.
  - ALUOp 10 decodes funct: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
  - An unknown funct gives ADD with RegWrite forced to 0.
- ALU:
  - SLT is a signed compare; its result is 1 or 0.
  - Zero = (ALUResult == 0).
  - The second operand is the sign-extended imm16 when ALUSrc=1.
- Writeback:
  - WriteReg = rd when RegDst=1, otherwise rt.
  - WriteData = ReadData (dmem) when MemtoReg=1, otherwise ALUResult.
  - Writes happen on the rising edge; writes to $0 are discarded.
  - Register reads are combinational and return the pre-edge value when the same register is written in the same cycle.
- Data memory:
  - Address = ALUResult[9:2], wrapping modulo 256; low address bits are ignored.
  - Reads are combinational; a CPU store writes rt on the rising edge.
  - If a data_init write and a CPU store hit the same edge, data_init wins at its own address; a store to a different address also completes.
- Next PC, priority Jump > taken branch > PC+4:
  - Jump: {PC+4[31:28], target26, 2'b00}.
  - Branch taken when (beq and Zero) or (bne and !Zero); taken target = PC+4 + (signext(imm16)<<2).
- Instruction memory:
  - A load write and a fetch from the same word in the same cycle: the fetch sees the old word.
  - Loading is intended while held in reset.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams;
  - ALU control codes;
  - ALUOp encodings.
- Sub-modules:
  - mips_main_control (opcode to control signals) is the one natural sub-module, instantiated as "control".
  - The datapath (PC, memories, register file, ALU) is instantiated as "datapath"; it exposes PC, Instruction, ALUControl, Zero, ALUResult, ReadData, RegWrite, WriteReg and WriteData for hierarchical probing.

Test Plan:
- Load program under reset, then release:
  - Program: 0x20010005 (addi $1,$0,5), 0x20020007 (addi $2,$0,7), 0x00221820 (add $3,$1,$2).
  - Required: RegValue1=5, RegValue2=7 and RegValue3=12 after 3 edges; PC=12.
- Store/load round trip:
  - Append 0xAC030190 (sw $3,400($0)) and 0x8C040190 (lw $4,400($0)).
  - Required: dmem word 100 = 12 and RegValue4=12.
- Branch:
  - beq $1,$1,+2 gives PC = PC+12.
  - bne $1,$1,+2 gives PC = PC+4.
  - Instructions in the skipped slots must not change any register.
- Jump and $0:
  - j to word 8 gives PC=32.
  - addi $0,$0,9 leaves RegValue0=0.
- Data init and Fibonacci:
  - Preload dmem via data_init, run an iterative Fibonacci loop (slt/beq/add/addi) with n=10.
  - Required: RegValue4 = 55 and dmem[100] = 55.
- Reset mid-run: asserting reset low asynchronously gives PC=0 and all RegValueN=0 immediately, while imem and dmem contents are retained.
